instr_mem_responder: RTL and testbench

Responder side of the instruction-fetch interface: accepts fetch requests carrying a 64-bit byte PC, reads a 32-bit instruction from an on-chip word array, and returns it through a valid/ready response channel with a small output buffer. A separate write port loads program words before or between runs. It sits between the fetch stage, which issues PCs and consumes instructions, and the program loader, which drives the write port.

---
 rtl/instr_mem_responder.sv | 116 +++++++++++
 tb/tb_instr_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// instr_mem_responder
// Instruction-fetch responder: word array, one-cycle read stage, response FIFO.
// Revision: 1.0
// ============================================================================
module instr_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int RSP_DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_instr_o,
  output logic [63:0] rsp_addr_o,
  output logic        rsp_err_o,
  input  logic        flush_i,
  input  logic        wr_en_i,
  input  logic [63:0] wr_addr_i,
  input  logic [31:0] wr_instr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]   OCC_FULL = (CW+1)'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic [63:0] rd_addr;

  logic [31:0] fifo_instr [RSP_DEPTH];
  logic [63:0] fifo_addr  [RSP_DEPTH];
  logic        fifo_err   [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        req_in_range;
  logic        wr_in_range;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic [CW:0] occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign req_in_range = (req_addr_i[1:0] == 2'b00) && (req_addr_i[63:AW+2] == '0);
  assign wr_in_range  = (wr_addr_i[1:0] == 2'b00) && (wr_addr_i[63:AW+2] == '0);

  // Credits count the read stage too, so every read-stage entry always has a FIFO slot.
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, rd_valid};
  assign req_ready_o = rst_ni && !flush_i && !wr_en_i && (occupancy < OCC_FULL);
  assign req_fire    = req_valid_i && req_ready_o;
  assign push        = rd_valid;
  assign pop         = (count != '0) && rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_in_range) begin
      mem[wr_addr_i[AW+1:2]] <= wr_instr_i;
    end
    if (req_fire && req_in_range) begin
      rd_data <= mem[req_addr_i[AW+1:2]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_addr  <= '0;
    end else begin
      rd_valid <= req_fire;
      if (req_fire) begin
        rd_err  <= !req_in_range;
        rd_addr <= req_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wr_ptr] <= rd_err ? 32'h0 : rd_data;
      fifo_addr[wr_ptr]  <= rd_addr;
      fifo_err[wr_ptr]   <= rd_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rsp_valid_o = (count != '0);
  assign rsp_instr_o = rsp_valid_o ? fifo_instr[rd_ptr] : 32'h0;
  assign rsp_addr_o  = rsp_valid_o ? fifo_addr[rd_ptr]  : 64'h0;
  assign rsp_err_o   = rsp_valid_o ? fifo_err[rd_ptr]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_instr_mem_responder
// Directed, table-driven bench for instr_mem_responder.
// Revision: 1.0
// ============================================================================
module tb_instr_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_instr_o;
  logic [63:0] rsp_addr_o;
  logic        rsp_err_o;
  logic        flush_i;
  logic        wr_en_i;
  logic [63:0] wr_addr_i;
  logic [31:0] wr_instr_i;

  int tests = 0;
  int fails = 0;

  instr_mem_responder #(.DEPTH(1024), .RSP_DEPTH(3)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_instr_o (rsp_instr_o),
    .rsp_addr_o  (rsp_addr_o),
    .rsp_err_o   (rsp_err_o),
    .flush_i     (flush_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_instr_i  (wr_instr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[10];
  logic [63:0] bp_addr[4];
  logic [31:0] bp_exp[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_word(input logic [63:0] a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_instr_i = d;
    #1;
    check("write_stalls_req", req_ready_o, 0);
    tick();
    wr_en_i = 1'b0;
  endtask

  // Single isolated fetch; response visible two edges after the request is presented.
  task automatic fetch(input string name, input logic [63:0] a, input logic [31:0] ei, input logic ee);
    rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_addr_i = a;
    #1;
    check({name, "_ready"}, req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    check({name, "_early"}, rsp_valid_o, 0);
    tick();
    check({name, "_valid"}, rsp_valid_o, 1);
    check({name, "_instr"}, rsp_instr_o, ei);
    check({name, "_addr"},  rsp_addr_o, a);
    check({name, "_err"},   rsp_err_o, ee);
    tick();
  endtask

  initial begin
    int idx;
    int got;

    vecs[0] = '{64'h0,                  32'h00500093, 1'b0};
    vecs[1] = '{64'h4,                  32'h00a00113, 1'b0};
    vecs[2] = '{64'h2,                  32'h0,        1'b1};
    vecs[3] = '{64'h8,                  32'h00f00193, 1'b0};
    vecs[4] = '{64'h1000,               32'h0,        1'b1};
    vecs[5] = '{64'hC,                  32'h01400213, 1'b0};
    vecs[6] = '{64'hFFC,                32'h12345678, 1'b0};
    vecs[7] = '{64'h4,                  32'h00a00113, 1'b0};
    vecs[8] = '{64'h8000_0000_0000_0000, 32'h0,       1'b1};
    vecs[9] = '{64'hFFE,                32'h0,        1'b1};
    bp_addr = '{64'h0, 64'h4, 64'h8, 64'hC};
    bp_exp  = '{32'h00500093, 32'h00a00113, 32'h00f00193, 32'h01400213};

    rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b0;
    flush_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_instr_i = '0;

    // Reset / idle
    repeat (3) tick();
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_instr", rsp_instr_o, 0);
    check("rst_rsp_addr",  rsp_addr_o, 0);
    check("rst_rsp_err",   rsp_err_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    rst_ni = 1'b1;
    #1;
    check("post_rst_req_ready", req_ready_o, 1);
    check("post_rst_rsp_valid", rsp_valid_o, 0);
    tick();

    // Program load, including dropped misaligned / out-of-range writes
    write_word(64'h0,   32'h00500093);
    write_word(64'h4,   32'h00a00113);
    write_word(64'h8,   32'h00f00193);
    write_word(64'hC,   32'h01400213);
    write_word(64'hFFC, 32'h12345678);
    write_word(64'h6,   32'hFFFFFFFF);
    write_word(64'h1000, 32'hFFFFFFFF);

    // Back-to-back fetch of 0x0 and 0x4
    rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 64'h0;
    tick();
    req_addr_i = 64'h4;
    #1;
    check("b2b_ready2", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    check("b2b_r0_valid", rsp_valid_o, 1);
    check("b2b_r0_instr", rsp_instr_o, 32'h00500093);
    check("b2b_r0_addr",  rsp_addr_o, 64'h0);
    check("b2b_r0_err",   rsp_err_o, 0);
    tick();
    check("b2b_r1_valid", rsp_valid_o, 1);
    check("b2b_r1_instr", rsp_instr_o, 32'h00a00113);
    check("b2b_r1_addr",  rsp_addr_o, 64'h4);
    tick();
    check("b2b_drained", rsp_valid_o, 0);

    // Table of isolated fetches: valid, misaligned and out-of-range
    for (int i = 0; i < 10; i++) begin
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].err);
    end

    // Back-pressure: only 3 credits, head stable, ordered drain
    idx = 0; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      rsp_ready_i = (c >= 6);
      req_valid_i = (idx < 4);
      req_addr_i  = (idx < 4) ? bp_addr[idx] : 64'h0;
      #1;
      if (c >= 2 && c < 6) check("bp_head_instr", rsp_instr_o, 32'h00500093);
      if (c == 5) begin
        check("bp_accepted", idx, 3);
        check("bp_full_ready", req_ready_o, 0);
      end
      if (rsp_valid_o && rsp_ready_i) begin
        check("bp_drain_instr", rsp_instr_o, bp_exp[got]);
        check("bp_drain_addr",  rsp_addr_o, bp_addr[got]);
        got++;
      end
      if (req_valid_i && req_ready_o) idx++;
      tick();
    end
    req_valid_i = 1'b0;
    check("bp_drain_count", got, 4);
    check("bp_empty_after", rsp_valid_o, 0);

    // Flush with three outstanding (two in FIFO, one in read stage)
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr_i = bp_addr[k];
      tick();
    end
    req_addr_i = 64'hC; flush_i = 1'b1;
    #1;
    check("flush_req_ready", req_ready_o, 0);
    tick();
    flush_i = 1'b0; req_valid_i = 1'b0;
    check("flush_rsp_valid", rsp_valid_o, 0);
    check("flush_rsp_instr", rsp_instr_o, 0);
    fetch("post_flush", 64'h8, 32'h00f00193, 1'b0);
    check("post_flush_empty", rsp_valid_o, 0);

    // Write collides with a request to the same word
    rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 64'h10;
    wr_en_i = 1'b1; wr_addr_i = 64'h10; wr_instr_i = 32'hDEADBEEF;
    #1;
    check("coll_stall", req_ready_o, 0);
    tick();
    wr_en_i = 1'b0;
    #1;
    check("coll_ready_next", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    tick();
    check("coll_valid", rsp_valid_o, 1);
    check("coll_instr", rsp_instr_o, 32'hDEADBEEF);
    check("coll_addr",  rsp_addr_o, 64'h10);
    tick();

    // Reset mid-operation drops outstanding requests, keeps array
    rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 64'h4;
    tick(); tick();
    req_valid_i = 1'b0; rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1; rsp_ready_i = 1'b1;
    #1;
    check("midrst_ready", req_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      check("midrst_no_rsp", rsp_valid_o, 0);
      tick();
    end
    fetch("midrst_mem", 64'h0, 32'h00500093, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
